// File: rtl/keypad_pkg.sv
// Shared constants, LCD handshake state type and key-vector helpers for the keypad entry path.
package keypad_pkg;

    localparam int unsigned NUM_KEYS  = 12;
    localparam int unsigned KEY_STAR  = 10;
    localparam int unsigned KEY_SHARP = 11;

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_BS   = 8'h08;
    localparam logic [7:0] ASC_CR   = 8'h0D;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } lcd_state_e;

    // Bit position of the highest set key; only meaningful for a one-hot vector.
    function automatic logic [3:0] key_index(logic [NUM_KEYS-1:0] keys);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Byte handshake from the keypad entry block to the LCD writer.
interface keypad_if;

    logic [7:0] lcd_data;
    logic       lcd_valid;
    logic       lcd_ready;

    modport master (
        output lcd_data,
        output lcd_valid,
        input  lcd_ready
    );

    modport slave (
        input  lcd_data,
        input  lcd_valid,
        output lcd_ready
    );

endinterface

// File: rtl/keypad_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output vector only follows
// the synced keys after they have been unchanged for DEBOUNCE_CYC cycles.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                changed;

    // sync2 is about to take a new value whenever the two stages disagree
    always_comb begin
        changed  = (sync1_q != sync2_q);
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= keys_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign keys_o = stable_q;

endmodule

// File: rtl/keypad_entry.sv
// Debounced keypad to press events, BCD entry buffer with backspace/commit, and an LCD echo
// channel that drops bytes (with a DROP pulse) rather than stall when the writer is busy.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned  DEBOUNCE_CYC = 16,
    parameter int unsigned  MAX_DIGITS   = 8,
    localparam int unsigned LenW         = $clog2(MAX_DIGITS + 1),
    localparam int unsigned BufW         = 4 * MAX_DIGITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_KEYS-1:0] keypad_i,
    keypad_if.master            lcd,
    output logic                chk_o,
    output logic                star_o,
    output logic                sharp_o,
    output logic [BufW-1:0]     entry_o,
    output logic [LenW-1:0]     entry_len_o,
    output logic                entry_valid_o,
    output logic                overflow_o,
    output logic                drop_o
);

    logic [NUM_KEYS-1:0] deb;
    logic                key_one, key_evt, armed_q, armed_d;
    logic [3:0]          key_idx;

    logic [BufW-1:0] buf_q, buf_d, entry_q, entry_d;
    logic [LenW-1:0] len_q, len_d, entry_len_q, entry_len_d;
    logic            ovf_q, ovf_d, entry_valid_d, star_d, sharp_d;
    logic            entry_valid_q, star_q, sharp_q;
    logic            have_byte;
    logic [7:0]      byte_val;

    lcd_state_e state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       drop_q, drop_d;

    keypad_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .keys_i(keypad_i),
        .keys_o(deb)
    );

    // One event per press: re-arm only once the debounced vector shows no valid key.
    always_comb begin
        key_one = $onehot(deb);
        key_idx = key_index(deb);
        key_evt = key_one && armed_q;
        armed_d = armed_q;
        if (!key_one) begin
            armed_d = 1'b1;
        end else if (key_evt) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        buf_d         = buf_q;
        len_d         = len_q;
        ovf_d         = ovf_q;
        entry_d       = entry_q;
        entry_len_d   = entry_len_q;
        entry_valid_d = 1'b0;
        star_d        = 1'b0;
        sharp_d       = 1'b0;
        have_byte     = 1'b0;
        byte_val      = '0;
        if (key_evt) begin
            if (key_idx == 4'(KEY_STAR)) begin
                star_d = 1'b1;
                if (len_q != '0) begin
                    buf_d     = buf_q >> 4;
                    len_d     = len_q - LenW'(1);
                    have_byte = 1'b1;
                    byte_val  = ASC_BS;
                end
            end else if (key_idx == 4'(KEY_SHARP)) begin
                sharp_d = 1'b1;
                if (len_q != '0) begin
                    entry_d       = buf_q;
                    entry_len_d   = len_q;
                    entry_valid_d = 1'b1;
                    buf_d         = '0;
                    len_d         = '0;
                    ovf_d         = 1'b0;
                    have_byte     = 1'b1;
                    byte_val      = ASC_CR;
                end
            end else if (len_q < LenW'(MAX_DIGITS)) begin
                buf_d     = (buf_q << 4) | BufW'(key_idx);
                len_d     = len_q + LenW'(1);
                have_byte = 1'b1;
                byte_val  = ASC_ZERO + {4'h0, key_idx};
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // A byte arriving while the writer still holds the previous one is discarded.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (have_byte) begin
                    state_d = StSend;
                    data_d  = byte_val;
                end
            end
            StSend: begin
                if (lcd.lcd_ready) begin
                    if (have_byte) begin
                        data_d = byte_val;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (have_byte) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q       <= 1'b1;
            buf_q         <= '0;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            entry_q       <= '0;
            entry_len_q   <= '0;
            entry_valid_q <= 1'b0;
            star_q        <= 1'b0;
            sharp_q       <= 1'b0;
            state_q       <= StIdle;
            data_q        <= '0;
            drop_q        <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            buf_q         <= buf_d;
            len_q         <= len_d;
            ovf_q         <= ovf_d;
            entry_q       <= entry_d;
            entry_len_q   <= entry_len_d;
            entry_valid_q <= entry_valid_d;
            star_q        <= star_d;
            sharp_q       <= sharp_d;
            state_q       <= state_d;
            data_q        <= data_d;
            drop_q        <= drop_d;
        end
    end

    assign lcd.lcd_valid  = (state_q == StSend);
    assign lcd.lcd_data   = data_q;
    assign chk_o          = key_one && !deb[KEY_STAR] && !deb[KEY_SHARP];
    assign star_o         = star_q;
    assign sharp_o        = sharp_q;
    assign entry_o        = entry_q;
    assign entry_len_o    = entry_len_q;
    assign entry_valid_o  = entry_valid_q;
    assign overflow_o     = ovf_q;
    assign drop_o         = drop_q;

endmodule
